// File: rtl/board_input_conditioner_pkg.sv
// Board-level constants for the mechanical input front-end: default channel
// count, the 10 ms debounce window at 100 MHz, and the channel index map.
package board_io_pkg;

    localparam int N_CH_DEFAULT            = 13;
    localparam int SYNC_STAGES_DEFAULT     = 2;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum int unsigned {
        SW0  = 0,
        SW1  = 1,
        SW2  = 2,
        SW3  = 3,
        SW4  = 4,
        SW5  = 5,
        SW6  = 6,
        SW7  = 7,
        BTNC = 8,
        BTND = 9,
        BTNL = 10,
        BTNR = 11,
        BTNU = 12
    } board_ch_e;

endpackage

// File: rtl/board_input_conditioner_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter, clean level,
// rise/fall pulses, toggle and sticky rise latch.
module input_debounce_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    input  logic clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o,
    output logic latch_o,
    output logic event_next_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   toggle_q, toggle_d;
    logic                   latch_q, latch_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Value has differed for the full window: accept it.
            level_d = sync;
            cnt_d   = '0;
            rise_d  = sync;
            fall_d  = ~sync;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        toggle_d = toggle_q ^ rise_d;
        // A rise in the same cycle as a clear keeps the latch set.
        latch_d  = rise_d | (latch_q & ~clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
            latch_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
            latch_q  <= latch_d;
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign toggle_o     = toggle_q;
    assign latch_o      = latch_q;
    assign event_next_o = rise_d | fall_d;

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions all board switches and buttons: one debounce channel per pin,
// plus a registered ANY_EVENT flag aligned with the per-channel pulses.
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int N_CH            = N_CH_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            GCLK,
    input  logic            RESETN,
    input  logic [N_CH-1:0] RAW_IN,
    input  logic [N_CH-1:0] LATCH_CLR,
    output logic [N_CH-1:0] LEVEL,
    output logic [N_CH-1:0] RISE,
    output logic [N_CH-1:0] FALL,
    output logic [N_CH-1:0] TOGGLE,
    output logic [N_CH-1:0] LATCH,
    output logic            ANY_EVENT
);

    logic [N_CH-1:0] event_next;
    logic            any_q, any_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        input_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk_i       (GCLK),
            .rst_ni      (RESETN),
            .raw_i       (RAW_IN[g]),
            .clr_i       (LATCH_CLR[g]),
            .level_o     (LEVEL[g]),
            .rise_o      (RISE[g]),
            .fall_o      (FALL[g]),
            .toggle_o    (TOGGLE[g]),
            .latch_o     (LATCH[g]),
            .event_next_o(event_next[g])
        );
    end

    assign any_d = |event_next;

    always_ff @(posedge GCLK) begin
        if (!RESETN) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign ANY_EVENT = any_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Bench for board_input_conditioner with 4 channels, 2 sync stages and a
// 4-cycle debounce window, checked every cycle against a reference model.
module tb_board_input_conditioner;

    localparam int N   = 4;
    localparam int SYN = 2;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [N-1:0] raw_in = '0;
    logic [N-1:0] latch_clr = '0;
    logic [N-1:0] level, rise, fall, toggle, latch;
    logic         any_event;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int rise_cnt [N];

    logic [N-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_tog = '0, m_latch = '0;
    logic         m_any = 1'b0;
    int           m_run [N];
    logic [N-1:0] pipe_q [$];

    always #5 clk = ~clk;

    board_input_conditioner #(
        .N_CH           (N),
        .SYNC_STAGES    (SYN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .GCLK     (clk),
        .RESETN   (resetn),
        .RAW_IN   (raw_in),
        .LATCH_CLR(latch_clr),
        .LEVEL    (level),
        .RISE     (rise),
        .FALL     (fall),
        .TOGGLE   (toggle),
        .LATCH    (latch),
        .ANY_EVENT(any_event)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    // Reference: sync is the raw input delayed SYN edges; a value is accepted
    // once it has differed from the level on DEB consecutive edges.
    task automatic model_edge();
        logic [N-1:0] s;
        if (!resetn) begin
            m_level = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_latch = '0; m_any = 1'b0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            pipe_q.delete();
            for (int i = 0; i < SYN; i++) pipe_q.push_back('0);
        end else begin
            s = pipe_q.pop_front();
            pipe_q.push_back(raw_in);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = (s[i] != m_level[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DEB) begin
                    m_run[i]   = 0;
                    m_level[i] = s[i];
                    if (s[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                end
            end
            m_tog   = m_tog ^ m_rise;
            m_latch = m_rise | (m_latch & ~latch_clr);
            m_any   = |(m_rise | m_fall);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cycle++;
        chk("level", 32'(level), 32'(m_level));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("toggle", 32'(toggle), 32'(m_tog));
        chk("latch", 32'(latch), 32'(m_latch));
        chk("any_event", 32'(any_event), 32'(m_any));
        for (int i = 0; i < N; i++) rise_cnt[i] += int'(rise[i]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) rise_cnt[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_run[i] = 0;
        for (int i = 0; i < SYN; i++) pipe_q.push_back('0);
        clear_counts();

        // Reset, then idle inputs: everything stays at 0.
        steps(3);
        resetn = 1'b1;
        steps(20);
        chk("idle_all_zero", 32'({level, rise, fall, toggle, latch, any_event}), 32'd0);

        // Channel 0 rise lands on edge SYN+DEB after the change.
        raw_in[0] = 1'b1;
        steps(5);
        chk("ch0_level_before", 32'(level[0]), 32'd0);
        step();
        chk("ch0_rise_edge6", 32'({level[0], rise[0], toggle[0], latch[0], any_event}), 32'h1f);
        step();
        chk("ch0_rise_edge7", 32'({rise[0], any_event}), 32'd0);

        // Channel 1 glitch of 3 cycles is rejected.
        clear_counts();
        raw_in[1] = 1'b1;
        steps(3);
        raw_in[1] = 1'b0;
        steps(10);
        chk("ch1_glitch_rise", 32'(rise_cnt[1]), 32'd0);
        chk("ch1_glitch_level", 32'(level[1]), 32'd0);

        // Channel 2 bounces then settles high: exactly one rise.
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            raw_in[2] = ~i[0];
            step();
        end
        steps(12);
        chk("ch2_bounce_rises", 32'(rise_cnt[2]), 32'd1);
        chk("ch2_bounce_level", 32'(level[2]), 32'd1);

        // Latch: clear coinciding with a new rise keeps it set.
        raw_in[0] = 1'b0;
        steps(8);
        chk("ch0_fallen", 32'(level[0]), 32'd0);
        chk("ch0_latch_held", 32'(latch[0]), 32'd1);
        raw_in[0] = 1'b1;
        steps(5);
        latch_clr[0] = 1'b1;
        step();
        latch_clr[0] = 1'b0;
        chk("ch0_set_wins", 32'({rise[0], latch[0]}), 32'h3);
        step();
        latch_clr[0] = 1'b1;
        step();
        latch_clr[0] = 1'b0;
        chk("ch0_latch_cleared", 32'(latch[0]), 32'd0);
        step();

        // Channel 3: reset mid-debounce discards the pending count.
        raw_in[3] = 1'b1;
        steps(2);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        clear_counts();
        steps(5);
        chk("ch3_level_pre", 32'(level[3]), 32'd0);
        step();
        chk("ch3_rise_after_reset", 32'({level[3], rise[3]}), 32'h3);
        steps(6);
        chk("ch3_single_rise", 32'(rise_cnt[3]), 32'd1);

        // Randomised phase: bursty inputs, random clears, rare resets.
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) raw_in[c] = ~raw_in[c];
            latch_clr = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            resetn = ($urandom_range(0, 99) != 0);
            step();
        end
        resetn = 1'b1;
        latch_clr = '0;
        steps(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
